xor_descrambler: RTL and testbench
==================================

// Module: xor_descrambler
// PURPOSE
//  Receive-side end of the ALU's XOR data path. Takes 32-bit words that were
//  XOR-scrambled with an LFSR keystream and restores the plaintext by
//  XOR-ing each word with the same keystream.
//  The block sits between the operand bus and the ALU input stage. It uses
//  valid/ready handshakes on both sides and one output register stage.
// PARAMETERS
//  WIDTH  32            data word width in bits
//  SEED   32'h0000_0001 keystream state loaded at reset; also used when seed_in==0
//  POLY   32'h8020_0003 Galois LFSR feedback mask
//  CNT_W  16            width of word_cnt
// PORTS
//  clk       in   1      rising-edge clock
//  rst       in   1      synchronous reset, active-high
//  in_valid  in   1      in_data is presented
//  in_ready  out  1      block can accept in_data this cycle
//  in_data   in   WIDTH  scrambled word
//  out_valid out  1      out_data holds a restored word
//  out_ready in   1      downstream takes out_data this cycle
//  out_data  out  WIDTH  descrambled word
//  reseed    in   1      load a new keystream state (one-cycle pulse)
//  seed_in   in   WIDTH  keystream state to load on reseed
//  word_cnt  out  CNT_W  number of words accepted since reset or reseed
// BEHAVIOUR
//  - Reset (rst=1 at clk edge): out_valid=0, out_data=0, word_cnt=0,
//    lfsr=SEED; par_err=0 when the option is built.
//    Reset mid-transfer discards the held word; it is not re-presented.
//  - Step function: nxt(s) = (s>>1) ^ (s[0] ? POLY : 0).
//  - Keystream word = current lfsr. The LFSR advances exactly once per
//    accepted word.
//  - in_ready = !out_valid || out_ready (combinational). There are no bubbles
//    under continuous flow, giving 1 word/cycle.
//  - Accept = in_valid && in_ready. On accept:
//    out_data <= in_data ^ k, out_valid <= 1, lfsr <= nxt(k), word_cnt += 1.
//  - Latency: 1 cycle from accept to out_valid.
//  - out_valid clears when out_ready=1 and no new accept occurs that cycle.
//  - While out_valid=1 && out_ready=0: out_data, lfsr and word_cnt are held.
//  - reseed: let s = (seed_in==0) ? SEED : seed_in. An all-zero state would
//    lock up the LFSR, which is why zero maps to SEED.
//    * Without accept: lfsr <= s, word_cnt <= 0.
//    * With accept in the same cycle: k = s, so the word uses the new seed;
//      lfsr <= nxt(s), word_cnt <= 1.
//    reseed does not affect out_valid or out_data already held.
//  - word_cnt wraps from 2^CNT_W-1 to 0 silently.
//  - Downstream must not drop out_valid's word. Upstream must hold in_data
//    stable while in_valid && !in_ready.
// CONFIGURATION
//  XOR_DESCR_PARITY_EN defined:
//   - Adds port in_parity (in, 1): even parity of the plaintext word.
//   - Adds port par_err (out, 1): registered alongside out_data on each accept.
//     par_err = ^(in_data ^ k) != in_parity.
//     Reset value 0. Held with out_data.
//  XOR_DESCR_PARITY_EN undefined:
//   - Neither port exists and no parity logic is built.
// TESTING
//  1 Reset with default SEED, then send in_data=0 twice with out_ready=1:
//    out_data=32'h0000_0001, then 32'h8020_0003; word_cnt=2.
//  2 Scramble/descramble loopback: 1000 random words through a model
//    scrambler with the same SEED, random in_valid/out_ready:
//    out_data == plaintext in order; no loss or duplication.
//  3 Backpressure: hold out_ready=0 with out_valid=1:
//    in_ready=0; out_data stable and lfsr held.
//    Release out_ready: next word uses the next key, no skip.
//  4 reseed with seed_in=0 in the same cycle as accept of in_data=0:
//    out_data=SEED; word_cnt=1.
//    reseed with seed_in=32'h1234_5678 and no accept: word_cnt=0.
//  5 rst asserted while out_valid=1 && out_ready=0:
//    next cycle out_valid=0, out_data=0, lfsr=SEED.
//  6 (PARITY_EN) send a word with in_parity flipped: par_err=1 for that word
//    only; correct parity -> par_err=0.

Source files
------------

// File: rtl/xor_descrambler.sv
// Restores plaintext by XOR-ing each scrambled word with a Galois LFSR keystream.
// Latency: one cycle from accept to out_valid, with one output register stage.
// Backpressure: in_ready = !out_valid || out_ready. Full rate is 1 word/cycle with no bubbles.
// Optional build macro XOR_DESCR_PARITY_EN adds in_parity/par_err plaintext parity checking.
module xor_descrambler #(
    parameter int            WIDTH = 32,
    parameter logic [WIDTH-1:0] SEED = 32'h0000_0001,
    parameter logic [WIDTH-1:0] POLY = 32'h8020_0003,
    parameter int            CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    input  logic             reseed,
    input  logic [WIDTH-1:0] seed_in,
`ifdef XOR_DESCR_PARITY_EN
    input  logic             in_parity,
    output logic             par_err,
`endif
    output logic [CNT_W-1:0] word_cnt
);

    logic [WIDTH-1:0] lfsr;
    logic [WIDTH-1:0] seed_sel;
    logic [WIDTH-1:0] key;
    logic             accept;

    // One Galois step: shift right, fold in the feedback mask when the LSB falls out.
    function automatic logic [WIDTH-1:0] lfsr_next(input logic [WIDTH-1:0] s);
        return (s >> 1) ^ (s[0] ? POLY : '0);
    endfunction

    // An all-zero seed would freeze the LFSR, so zero falls back to SEED.
    // A reseed coinciding with an accept keys that word with the new seed.
    always_comb begin
        seed_sel = (seed_in == '0) ? SEED : seed_in;
        key      = reseed ? seed_sel : lfsr;
        in_ready = !out_valid || out_ready;
        accept   = in_valid && in_ready;
    end

    // Output register, keystream state and word counter advance together on accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            lfsr      <= SEED;
            word_cnt  <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_data  <= in_data ^ key;
            lfsr      <= lfsr_next(key);
            word_cnt  <= reseed ? CNT_W'(1) : word_cnt + CNT_W'(1);
        end else begin
            if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (reseed) begin
                lfsr     <= seed_sel;
                word_cnt <= '0;
            end
        end
    end

`ifdef XOR_DESCR_PARITY_EN
    // Parity flag travels with the word it describes and is held along with out_data.
    always_ff @(posedge clk) begin
        if (rst) begin
            par_err <= 1'b0;
        end else if (accept) begin
            par_err <= (^(in_data ^ key)) != in_parity;
        end
    end
`endif

endmodule

// File: tb/tb_xor_descrambler.sv
// Bench for xor_descrambler: directed literal checks plus a random scramble/descramble loopback.
// A behavioural keystream model in the bench predicts every output word and count.
// Random backpressure exercises in_ready/out_ready both ways.
module tb_xor_descrambler;

    localparam logic [31:0] SEED = 32'h0000_0001;
    localparam logic [31:0] POLY = 32'h8020_0003;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic        reseed = 1'b0;
    logic [31:0] seed_in = '0;
    logic [15:0] word_cnt;
`ifdef XOR_DESCR_PARITY_EN
    logic        in_parity = 1'b0;
    logic        par_err;
`endif

    xor_descrambler dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .reseed    (reseed),
        .seed_in   (seed_in),
`ifdef XOR_DESCR_PARITY_EN
        .in_parity (in_parity),
        .par_err   (par_err),
`endif
        .word_cnt  (word_cnt)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] step(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? POLY : 32'h0);
    endfunction

    // Model state: pending output words, keystream, accepted-word count.
    logic [31:0] exp_q[$];
    logic        par_q[$];
    logic [31:0] pt_q[$];
    logic [31:0] m_key = SEED;
    logic [15:0] m_cnt = '0;
    bit          run = 0;
    bit          pt_mode = 0;
    int          received = 0;

    // Compare process: checks outputs against the model, then applies this cycle's inputs to it.
    always @(negedge clk) begin
        if (run) begin
            logic [31:0] s, k;
            chk("out_valid", {31'b0, out_valid}, {31'b0, exp_q.size() != 0});
            chk("word_cnt", {16'b0, word_cnt}, {16'b0, m_cnt});
            chk("in_ready", {31'b0, in_ready}, {31'b0, (exp_q.size() == 0) || out_ready});
            if (out_valid && exp_q.size() != 0) begin
                chk("out_data", out_data, exp_q[0]);
`ifdef XOR_DESCR_PARITY_EN
                chk("par_err", {31'b0, par_err}, {31'b0, par_q[0]});
`endif
            end
            if (rst) begin
                exp_q.delete();
                par_q.delete();
                m_key = SEED;
                m_cnt = '0;
            end else begin
                if (out_valid && out_ready && exp_q.size() != 0) begin
                    void'(exp_q.pop_front());
                    void'(par_q.pop_front());
                    if (pt_mode) begin
                        received++;
                        if (pt_q.size() == 0) chk("loopback_extra", 32'h1, 32'h0);
                        else chk("loopback_data", out_data, pt_q.pop_front());
                    end
                end
                s = (seed_in == 32'h0) ? SEED : seed_in;
                k = reseed ? s : m_key;
                if (in_valid && in_ready) begin
                    exp_q.push_back(in_data ^ k);
`ifdef XOR_DESCR_PARITY_EN
                    par_q.push_back((^(in_data ^ k)) != in_parity);
`else
                    par_q.push_back(1'b0);
`endif
                    m_key = step(k);
                    m_cnt = reseed ? 16'd1 : m_cnt + 16'd1;
                end else if (reseed) begin
                    m_key = s;
                    m_cnt = '0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; reseed = 1'b0; out_ready = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        logic [31:0] sk, p;
        bit have;
        int sent, cyc;

        tick();
        tick();
        run = 1;
        chk("reset_out_valid", {31'b0, out_valid}, 32'h0);
        chk("reset_out_data", out_data, 32'h0);
        chk("reset_word_cnt", {16'b0, word_cnt}, 32'h0);
        rst = 1'b0;

        // Two zero words expose the raw keystream.
        in_valid = 1; in_data = 0; out_ready = 1;
        tick();
        chk("t1_word0", out_data, 32'h0000_0001);
        tick();
        chk("t1_word1", out_data, 32'h8020_0003);
        chk("t1_cnt", {16'b0, word_cnt}, 32'd2);
        in_valid = 0;
        tick();

        // Backpressure holds data and keystream; release continues with the next key.
        do_reset();
        in_valid = 1; in_data = 0; out_ready = 0;
        tick();
        chk("t3_first", out_data, 32'h0000_0001);
        chk("t3_in_ready", {31'b0, in_ready}, 32'h0);
        repeat (3) tick();
        chk("t3_hold_data", out_data, 32'h0000_0001);
        chk("t3_hold_cnt", {16'b0, word_cnt}, 32'd1);
        out_ready = 1;
        tick();
        chk("t3_release", out_data, 32'h8020_0003);
        tick();
        chk("t3_third", out_data, 32'hC030_0002);
        chk("t3_cnt", {16'b0, word_cnt}, 32'd3);
        in_valid = 0;
        tick();

        // Reseed with zero coinciding with accept, then reseed alone.
        do_reset();
        reseed = 1; seed_in = 0; in_valid = 1; in_data = 0; out_ready = 1;
        tick();
        chk("t4_seed_word", out_data, 32'h0000_0001);
        chk("t4_cnt1", {16'b0, word_cnt}, 32'd1);
        seed_in = 32'h1234_5678; in_valid = 0;
        tick();
        chk("t4_cnt0", {16'b0, word_cnt}, 32'd0);
        reseed = 0; in_valid = 1;
        tick();
        chk("t4_new_seed", out_data, 32'h1234_5678);
        in_valid = 0;
        tick();

        // Reset while a word is stalled downstream.
        do_reset();
        in_valid = 1; in_data = 32'h5; out_ready = 0;
        tick();
        in_valid = 0; rst = 1;
        tick();
        chk("t5_valid", {31'b0, out_valid}, 32'h0);
        chk("t5_data", out_data, 32'h0);
        rst = 0; in_valid = 1; in_data = 0; out_ready = 1;
        tick();
        chk("t5_seed", out_data, 32'h0000_0001);
        in_valid = 0;
        tick();

`ifdef XOR_DESCR_PARITY_EN
        // Plaintext 1 has odd parity; 0x80200003 has even parity.
        do_reset();
        in_valid = 1; in_data = 0; out_ready = 1; in_parity = 0;
        tick();
        chk("t6_bad_par", {31'b0, par_err}, 32'h1);
        in_parity = 0;
        tick();
        chk("t6_good_par", {31'b0, par_err}, 32'h0);
        in_valid = 0;
        tick();
`endif

        // Random loopback through a bench-side scrambler keyed from SEED.
        do_reset();
        pt_mode = 1;
        sk = SEED; have = 0; sent = 0; cyc = 0; p = 0;
        while (sent < 1000 && cyc < 20000) begin
            if (!have && $urandom_range(0, 3) != 0) begin
                p = $urandom;
                have = 1;
                in_data = p ^ sk;
                in_valid = 1;
`ifdef XOR_DESCR_PARITY_EN
                in_parity = (^p) ^ ($urandom_range(0, 7) == 0);
`endif
            end
            out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (in_valid && in_ready) begin
                pt_q.push_back(p);
                sk = step(sk);
                sent++;
                have = 0;
            end
            tick();
            if (!have) in_valid = 0;
            cyc++;
        end
        in_valid = 0; out_ready = 1;
        repeat (5) tick();
        chk("loopback_sent", sent, 32'd1000);
        chk("loopback_received", received, 32'd1000);
        chk("loopback_leftover", pt_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
